// File: rtl/sockit_spi_flash_rsp.sv
// SPI flash responder: serves mode-0 read commands out of a 32-bit memory bus.
// Define SOCKIT_SPI_FAST_READ_EN to accept fast read (0x0B) with 8 dummy clocks.
module sockit_spi_flash_rsp #(
    parameter int BAW = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spi_sclk,
    input  logic           spi_ss_n,
    input  logic           spi_mosi,
    output logic           spi_miso,
    output logic           spi_moe,
    output logic           bso_ren,
    output logic [BAW-1:0] bso_adr,
    input  logic [31:0]    bso_rdt,
    input  logic           bso_wrq
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADR    = 3'd2,
`ifdef SOCKIT_SPI_FAST_READ_EN
        S_DUMMY  = 3'd3,
`endif
        S_DATA   = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t      state;
    logic [2:0]  sclk_q;
    logic [1:0]  ss_q;
    logic [1:0]  mosi_q;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        ss_s;
    logic        mosi_s;
    logic [4:0]  cnt;
    logic [2:0]  bcnt;
    logic [6:0]  sh;
    logic [23:0] adr;
    logic [23:0] adr_nx;
    logic [7:0]  tx;
    logic [31:0] wbuf [2];
    logic [1:0]  valid;
    logic        pend;
    logic [23:2] pend_adr;
    logic        fidx;
    logic        stale;
    logic [31:0] cur_word;
    logic [7:0]  cur_byte;
`ifdef SOCKIT_SPI_FAST_READ_EN
    logic        fast;
`endif

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_s      = ss_q[1];
    assign mosi_s    = mosi_q[1];
    assign adr_nx    = {adr[22:0], mosi_s};

    // Byte lanes are little endian; a missing word reads as all ones.
    always_comb begin
        cur_word = wbuf[adr[2]];
        cur_byte = 8'hFF;
        if (valid[adr[2]])
            cur_byte = cur_word[{adr[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sclk_q   <= 3'b000;
            ss_q     <= 2'b11;
            mosi_q   <= 2'b00;
            cnt      <= 5'd0;
            bcnt     <= 3'd0;
            sh       <= 7'd0;
            adr      <= 24'd0;
            tx       <= 8'hFF;
            wbuf[0]  <= 32'd0;
            wbuf[1]  <= 32'd0;
            valid    <= 2'b00;
            pend     <= 1'b0;
            pend_adr <= 22'd0;
            fidx     <= 1'b0;
            stale    <= 1'b0;
            spi_miso <= 1'b1;
            spi_moe  <= 1'b0;
            bso_ren  <= 1'b0;
            bso_adr  <= '0;
`ifdef SOCKIT_SPI_FAST_READ_EN
            fast     <= 1'b0;
`endif
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            ss_q   <= {ss_q[0], spi_ss_n};
            mosi_q <= {mosi_q[0], spi_mosi};

            // Bus side: one read in flight, queued request waits for it.
            if (bso_ren && !bso_wrq) begin
                bso_ren <= 1'b0;
                if (!stale) begin
                    wbuf[fidx]  <= bso_rdt;
                    valid[fidx] <= 1'b1;
                end
                stale <= 1'b0;
            end else if (!bso_ren && pend) begin
                bso_ren <= 1'b1;
                bso_adr <= {pend_adr[BAW-1:2], 2'b00};
                fidx    <= pend_adr[2];
                pend    <= 1'b0;
            end

            if (ss_s) begin
                state    <= S_IDLE;
                cnt      <= 5'd0;
                bcnt     <= 3'd0;
                valid    <= 2'b00;
                pend     <= 1'b0;
                spi_miso <= 1'b1;
                spi_moe  <= 1'b0;
                // A read still outstanding belongs to the old transfer.
                stale    <= (bso_ren && bso_wrq) || (!bso_ren && pend);
`ifdef SOCKIT_SPI_FAST_READ_EN
                fast     <= 1'b0;
`endif
            end else begin
                unique case (state)
                    S_IDLE: begin
                        state <= S_CMD;
                        cnt   <= 5'd0;
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            sh  <= {sh[5:0], mosi_s};
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cnt <= 5'd0;
                                if ({sh, mosi_s} == 8'h03)
                                    state <= S_ADR;
`ifdef SOCKIT_SPI_FAST_READ_EN
                                else if ({sh, mosi_s} == 8'h0B) begin
                                    state <= S_ADR;
                                    fast  <= 1'b1;
                                end
`endif
                                else
                                    state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADR: begin
                        if (sclk_rise) begin
                            adr <= adr_nx;
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd23) begin
                                cnt      <= 5'd0;
                                bcnt     <= 3'd0;
                                pend     <= 1'b1;
                                pend_adr <= adr_nx[23:2];
                                spi_moe  <= 1'b1;
                                state    <= S_DATA;
`ifdef SOCKIT_SPI_FAST_READ_EN
                                if (fast)
                                    state <= S_DUMMY;
`endif
                            end
                        end
                    end
`ifdef SOCKIT_SPI_FAST_READ_EN
                    S_DUMMY: begin
                        if (sclk_rise) begin
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cnt   <= 5'd0;
                                state <= S_DATA;
                            end
                        end
                    end
`endif
                    S_DATA: begin
                        if (sclk_fall) begin
                            if (bcnt == 3'd0) begin
                                spi_miso <= cur_byte[7];
                                tx       <= {cur_byte[6:0], 1'b1};
                                adr      <= adr + 24'd1;
                                bcnt     <= 3'd1;
                                // Last byte of the word: free it, fetch the next.
                                if (adr[1:0] == 2'd3) begin
                                    valid[adr[2]] <= 1'b0;
                                    pend          <= 1'b1;
                                    pend_adr      <= adr[23:2] + 22'd1;
                                end
                            end else begin
                                spi_miso <= tx[7];
                                tx       <= {tx[6:0], 1'b1};
                                bcnt     <= bcnt + 3'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        spi_moe <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
